// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: operating mode, runtime configuration, transmit FSM
// states and transmit interrupt flags.
package uart_defs;

    typedef enum logic {
        HALFDUPLEX = 1'b0,
        FULLDUPLEX = 1'b1
    } Mode_t;

    typedef struct packed {
        Mode_t mode;
        logic  flush_tx;
    } Config_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_SHIFT,
        TX_PARITY,
        TX_STOP
    } TXState_t;

    typedef struct packed {
        logic frame_done;
        logic fifo_empty;
    } TXIrqFlags_t;

    localparam int UART_DATA_BITS = 8;
    localparam logic [UART_DATA_BITS-1:0] TX_BIT_FIRST = 8'h01;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with an extra pointer bit to tell full from empty, a
// synchronous flush and a level output. Head data is visible without a pop.
module fifo_sync #(
    parameter int data_size   = 8,
    parameter int buffer_size = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [data_size-1:0]         push_data,
    input  logic                         pop,
    output logic [data_size-1:0]         pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(buffer_size):0] level
);

    localparam int AW = $clog2(buffer_size);

    logic [data_size-1:0] mem [buffer_size];
    logic [AW:0]          wr_ptr_reg;
    logic [AW:0]          rd_ptr_reg;
    logic                 wr_en;
    logic                 rd_en;

    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign level    = wr_ptr_reg - rd_ptr_reg;
    assign wr_en    = push && !full && !flush;
    assign rd_en    = pop && !empty;
    assign pop_data = mem[rd_ptr_reg[AW-1:0]];

    // Storage carries no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered bytes sent as start, 8 data bits LSB first,
// even parity and stop, paced by a one-cycle bit-rate strobe.
module uart_tx
    import uart_defs::*;
#(
    parameter int fifo_buffer_size = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tck_en,
    input  logic [7:0]  tx_d_i,
    input  logic        tx_d_valid_i,
    output logic        tx_d_ready_o,
    output logic        tx_full_o,
    output logic        tx_empty_o,
    output logic        tx_o,
    output logic        tx_rts_n_o,
    input  logic        tx_cts_n_i,
    input  logic        tx_enable_i,
    output logic        tx_busy_o,
    output TXIrqFlags_t tx_irq_flags_o,
    input  Config_t     uart_config_i
);

    localparam int LW = $clog2(fifo_buffer_size) + 1;

    TXState_t    state_reg;
    logic [7:0]  shift_reg;
    logic [7:0]  bit_cnt_reg;
    logic        parity_reg;
    logic        tx_reg;
    logic        busy_reg;
    logic        rts_n_reg;
    TXIrqFlags_t irq_reg;

    logic          go;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_head;
    logic [LW-1:0] fifo_level;
    logic          last_pop;

    assign go         = (uart_config_i.mode == FULLDUPLEX) || tx_enable_i;
    assign fifo_push  = tx_d_valid_i && !fifo_full;
    // Frames may start from IDLE or straight out of STOP, giving no idle gap.
    assign fifo_pop   = tck_en && go && !fifo_empty && !tx_cts_n_i &&
                        ((state_reg == TX_IDLE) || (state_reg == TX_STOP));
    assign last_pop   = fifo_pop && (fifo_level == LW'(1)) &&
                        !(fifo_push && !uart_config_i.flush_tx);

    fifo_sync #(
        .data_size   (8),
        .buffer_size (fifo_buffer_size)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (uart_config_i.flush_tx),
        .push      (fifo_push),
        .push_data (tx_d_i),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign tx_d_ready_o   = !fifo_full;
    assign tx_full_o      = fifo_full;
    assign tx_empty_o     = fifo_empty;
    assign tx_o           = tx_reg;
    assign tx_busy_o      = busy_reg;
    assign tx_rts_n_o     = rts_n_reg;
    assign tx_irq_flags_o = irq_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= TX_IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            parity_reg  <= 1'b0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
            rts_n_reg   <= 1'b1;
            irq_reg     <= '0;
        end else begin
            rts_n_reg          <= !(go && (!fifo_empty || busy_reg));
            irq_reg.frame_done <= 1'b0;
            irq_reg.fifo_empty <= last_pop;
            if (tck_en) begin
                case (state_reg)
                    TX_IDLE, TX_STOP: begin
                        if (state_reg == TX_STOP) begin
                            irq_reg.frame_done <= 1'b1;
                            busy_reg           <= 1'b0;
                        end
                        if (fifo_pop) begin
                            shift_reg   <= fifo_head;
                            bit_cnt_reg <= TX_BIT_FIRST;
                            parity_reg  <= 1'b0;
                            tx_reg      <= 1'b0;
                            busy_reg    <= 1'b1;
                            state_reg   <= TX_START;
                        end else begin
                            tx_reg    <= 1'b1;
                            state_reg <= TX_IDLE;
                        end
                    end
                    TX_START, TX_SHIFT: begin
                        // The one-hot marker falls off the top once all eight bits are out.
                        if (state_reg == TX_SHIFT && bit_cnt_reg == '0) begin
                            tx_reg    <= parity_reg;
                            state_reg <= TX_PARITY;
                        end else begin
                            tx_reg      <= shift_reg[0];
                            shift_reg   <= {1'b0, shift_reg[7:1]};
                            parity_reg  <= parity_reg ^ shift_reg[0];
                            bit_cnt_reg <= bit_cnt_reg << 1;
                            state_reg   <= TX_SHIFT;
                        end
                    end
                    TX_PARITY: begin
                        tx_reg    <= 1'b1;
                        state_reg <= TX_STOP;
                    end
                    default: begin
                        tx_reg    <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= TX_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a transaction-level model predicts frames and
// flags; a line monitor decodes tx_o at each bit strobe and checks frames.
module tb_uart_tx;
    import uart_defs::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tck_en = 1'b0;
    logic [7:0]  tx_d = '0;
    logic        valid = 1'b0;
    logic        ready, full_o, empty_o, tx_o, rts_n, busy;
    logic        cts_n = 1'b1;
    logic        tx_enable = 1'b0;
    TXIrqFlags_t irq;
    Config_t     cfg = '{mode: FULLDUPLEX, flush_tx: 1'b0};

    uart_tx #(.fifo_buffer_size(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .tck_en         (tck_en),
        .tx_d_i         (tx_d),
        .tx_d_valid_i   (valid),
        .tx_d_ready_o   (ready),
        .tx_full_o      (full_o),
        .tx_empty_o     (empty_o),
        .tx_o           (tx_o),
        .tx_rts_n_o     (rts_n),
        .tx_cts_n_i     (cts_n),
        .tx_enable_i    (tx_enable),
        .tx_busy_o      (busy),
        .tx_irq_flags_o (irq),
        .uart_config_i  (cfg)
    );

    always #5 clk = ~clk;

    // Bit strobe: one cycle high every four clocks.
    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #1 tck_en = 1'b1;
            @(posedge clk);
            #1 tck_en = 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] data;
        int         tick;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mq[$];
    int         rem = 0;
    int         m_tick = 0;
    logic       fd_exp = 1'b0, fe_exp = 1'b0, rts_exp = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            mq.delete(); exp_q.delete();
            rem = 0; m_tick = 0;
            fd_exp = 1'b0; fe_exp = 1'b0; rts_exp = 1'b1;
            chk("rst_tx_o", int'(tx_o), 1);
            chk("rst_busy", int'(busy), 0);
            chk("rst_rts_n", int'(rts_n), 1);
            chk("rst_irq", int'(irq), 0);
            chk("rst_empty", int'(empty_o), 1);
            chk("rst_full", int'(full_o), 0);
            chk("rst_ready", int'(ready), 1);
        end else begin
            logic go, push, start;
            exp_t e;
            chk("empty", int'(empty_o), int'(mq.size() == 0));
            chk("full", int'(full_o), int'(mq.size() == DEPTH));
            chk("ready", int'(ready), int'(mq.size() < DEPTH));
            chk("busy", int'(busy), int'(rem > 0));
            chk("rts_n", int'(rts_n), int'(rts_exp));
            chk("irq_frame_done", int'(irq.frame_done), int'(fd_exp));
            chk("irq_fifo_empty", int'(irq.fifo_empty), int'(fe_exp));
            go    = (cfg.mode == FULLDUPLEX) || tx_enable;
            push  = valid && (mq.size() < DEPTH);
            start = tck_en && (rem <= 1) && go && !cts_n && (mq.size() > 0);
            rts_exp = !(go && (mq.size() > 0 || rem > 0));
            fd_exp  = tck_en && (rem == 1);
            fe_exp  = start && (mq.size() == 1) && !(push && !cfg.flush_tx);
            if (start) begin
                e.data = mq.pop_front();
                e.tick = m_tick + 1;
                exp_q.push_back(e);
                rem = 11;
            end else if (tck_en && rem > 0) begin
                rem--;
            end
            if (cfg.flush_tx) mq.delete();
            else if (push) mq.push_back(tx_d);
            if (tck_en) m_tick++;
        end
    end

    // ---------------- line monitor ----------------
    int         mon_tick = 0;
    int         mon_pos = -1;
    logic       mon_unexp = 1'b0;
    logic [9:0] bits;

    always @(negedge clk) begin
        if (rst) begin
            mon_pos = -1; mon_tick = 0; mon_unexp = 1'b0;
        end else if (tck_en) begin
            if (mon_pos < 0) begin
                if (exp_q.size() > 0 && exp_q[0].tick < mon_tick) begin
                    errors++; checks++;
                    $display("FAIL missing_frame: got idle line expected start of %02h at tick %0d", exp_q[0].data, exp_q[0].tick);
                    void'(exp_q.pop_front());
                end
                if (tx_o == 1'b0) begin
                    mon_pos = 0;
                    mon_unexp = (exp_q.size() == 0);
                    if (mon_unexp) begin
                        errors++; checks++;
                        $display("FAIL unexpected_frame: got start bit at tick %0d expected idle", mon_tick);
                    end else begin
                        chk("start_tick", mon_tick, exp_q[0].tick);
                    end
                end
            end else begin
                bits[mon_pos] = tx_o;
                mon_pos++;
                if (mon_pos == 10) begin
                    mon_pos = -1;
                    if (!mon_unexp) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("frame_data", int'(bits[7:0]), int'(e.data));
                        chk("frame_parity", int'(bits[8]), int'(^e.data));
                        chk("frame_stop", int'(bits[9]), 1);
                        $display("frame data=%02h parity=%0d stop=%0d", bits[7:0], bits[8], bits[9]);
                    end
                end
            end
            mon_tick++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        logic acc = 1'b0;
        valid = 1'b1;
        tx_d  = d;
        for (int k = 0; k < 400 && !acc; k++) begin
            @(negedge clk);
            acc = ready;
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        if (!acc) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_busy();
        logic seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            seen = busy;
        end
        @(posedge clk);
        #1;
        if (!seen) chk("busy_timeout", 0, 1);
    endtask

    task automatic drain(input int budget);
        logic done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && (mq.size() == 0) && (rem == 0) && (mon_pos < 0);
        end
        cyc(1);
        if (!done) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        #1 rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cts_n = 1'b0;
        cyc(2);

        push_byte(8'hA5); drain(200);
        push_byte(8'h07); drain(200);

        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
        drain(400);

        // Fill with the peer holding us off.
        cts_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) push_byte(8'(8'hC0 + i));
        valid = 1'b1; tx_d = 8'hEE;
        cyc(3);
        chk("full_after_fill", int'(full_o), 1);
        chk("ready_after_fill", int'(ready), 0);
        chk("line_idle_held", int'(tx_o), 1);
        valid = 1'b0;
        cts_n = 1'b0;
        drain(1000);

        // Clear-to-send dropped mid-frame.
        for (int i = 0; i < 3; i++) push_byte(8'(8'h3C ^ i));
        wait_busy(); cyc(6);
        cts_n = 1'b1;
        cyc(80);
        chk("line_idle_cts", int'(tx_o), 1);
        cts_n = 1'b0;
        drain(400);

        // Flush mid-frame.
        for (int i = 0; i < 4; i++) push_byte(8'(8'h90 + i));
        wait_busy(); cyc(6);
        cfg.flush_tx = 1'b1; cyc(1); cfg.flush_tx = 1'b0; cyc(1);
        chk("empty_after_flush", int'(empty_o), 1);
        drain(200);

        // Reset during a data bit of 0xFF.
        push_byte(8'hFF);
        wait_busy(); cyc(10);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_tx_o", int'(tx_o), 1);
        chk("async_rst_busy", int'(busy), 0);
        cyc(2); rst = 1'b0; cyc(1);
        push_byte(8'h5A); drain(200);

        // Reset during a start bit.
        push_byte(8'h00);
        wait_busy();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_start_tx_o", int'(tx_o), 1);
        cyc(2); rst = 1'b0; cyc(1);

        // Randomised traffic with flow control, duplex mode and flush.
        for (int i = 0; i < 1500; i++) begin
            valid     = ($urandom_range(0, 2) != 0);
            tx_d      = 8'($urandom);
            if ($urandom_range(0, 15) == 0) cts_n = ~cts_n;
            if ($urandom_range(0, 31) == 0) cfg.mode = Mode_t'($urandom_range(0, 1));
            tx_enable = ($urandom_range(0, 3) != 0);
            cfg.flush_tx = ($urandom_range(0, 99) == 0);
            cyc(1);
        end
        valid = 1'b0; cfg.flush_tx = 1'b0; cfg.mode = FULLDUPLEX; cts_n = 1'b0;
        drain(2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, the transmit-side counterpart of the UART receive path in the same UART IP.
- Accepts bytes from the system side through a valid/ready interface into an internal synchronous FIFO.
- Serialises each byte as one frame: 1 start bit, 8 data bits LSB first, 1 even-parity bit, 1 stop bit.
- Bit timing comes from a one-cycle bit-rate strobe. Runs entirely in the system clock domain.

Parameters:
- fifo_buffer_size, 8, TX FIFO depth in bytes; must be a power of two and at least 2.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- tck_en  in  1  bit-rate strobe; one clk cycle high per UART bit period.
- tx_d_i  in  8  byte to enqueue.
- tx_d_valid_i  in  1  enqueue request.
- tx_d_ready_o  out  1  FIFO not full; enqueue happens when valid and ready are both high.
- tx_full_o  out  1  FIFO full.
- tx_empty_o  out  1  FIFO empty.
- tx_o  out  1  serial line; idles high.
- tx_rts_n_o  out  1  active-low request-to-send; low while data is pending or a frame is in flight.
- tx_cts_n_i  in  1  active-low clear-to-send from the peer.
- tx_enable_i  in  1  half-duplex transmit enable.
- tx_busy_o  out  1  a frame is in flight.
- tx_irq_flags_o  out  TXIrqFlags_t  interrupt pulses: frame_done, fifo_empty.
- uart_config_i  in  Config_t  fields used: mode, flush_tx.

Behaviour:
Reset values:
- tx_o=1, tx_rts_n_o=1, tx_busy_o=0, all irq flags 0.
- FIFO empty, so tx_empty_o=1, tx_full_o=0, tx_d_ready_o=1.
- State is TX_IDLE.
- Reset asserted mid-frame aborts the frame immediately: tx_o returns to 1 asynchronously and FIFO contents are lost.

Gating and outputs:
- go = (uart_config_i.mode == FULLDUPLEX || tx_enable_i).
- tx_o is driven from a flop. The FSM advances only on cycles with tck_en=1; between strobes all state holds.
- tx_rts_n_o = ~(go & (~tx_empty_o | tx_busy_o)), registered.

FSM (RXState_t sibling TXState_t: TX_IDLE, TX_START, TX_SHIFT, TX_PARITY, TX_STOP):
- TX_IDLE: on tck_en, if go, FIFO non-empty and tx_cts_n_i=0:
  - pop the FIFO head into an 8-bit shift register;
  - load the bit counter with one-hot 8'h01 and clear the parity accumulator;
  - drive tx_o<=0, set tx_busy_o, go to TX_START.
  - Otherwise tx_o stays 1.
- TX_START: on tck_en, tx_o<=shift[0], shift right, parity ^= shift[0], counter<<=1, go to TX_SHIFT.
- TX_SHIFT:
  - On tck_en, if counter[7] was set before shifting: tx_o<=parity accumulator (XOR of all 8 data bits), go to TX_PARITY.
  - Otherwise send the next data bit as in TX_START.
- TX_PARITY: on tck_en, tx_o<=1 (stop bit), go to TX_STOP.
- TX_STOP: on tck_en:
  - pulse frame_done for one clk cycle and clear tx_busy_o;
  - enter TX_IDLE in the same tck_en cycle and evaluate the IDLE start condition, so back-to-back frames have no idle gap.
- Frame length on the line is exactly 11 bit periods. The first start-bit edge appears one clk cycle after the qualifying tck_en.

Flow control:
- tx_cts_n_i and go are sampled only at frame start. Deasserting either mid-frame does not truncate the frame.

FIFO:
- Push when valid & ready. Pop at frame start.
- A simultaneous push and pop when full is not permitted, because ready=0 when full.
- A push into an empty FIFO is poppable one cycle later at the earliest.
- Pointers wrap modulo fifo_buffer_size, with an extra bit to distinguish full from empty.
- fifo_empty irq pulses one cycle when a pop makes the FIFO empty.

Flush:
- uart_config_i.flush_tx high clears the FIFO synchronously; it takes priority over a same-cycle push.
- A frame already in flight completes normally.

Decomposition:
- uart_defs package gains TXState_t, TXIrqFlags_t {frame_done, fifo_empty}, and flush_tx in Config_t, next to the existing mode/FULLDUPLEX definitions.
- One sub-module: fifo_sync (data_size, buffer_size), a single-clock FIFO with full, empty and flush.

Test Plan:
- Send 0xA5, cts_n=0, FULLDUPLEX: tx_o per tck_en is 0,1,0,1,0,0,1,0,1,0,1 (parity 0); frame_done pulses once; tx_busy_o low afterwards.
- Send 0x07: data bits 1,1,1,0,0,0,0,0, parity bit 1, stop 1.
- Push 0x11, 0x22, 0x33 back-to-back: three contiguous 11-bit frames with no idle bit; fifo_empty pulses at the third pop.
- Push fifo_buffer_size+1 bytes with cts_n=1: tx_full_o=1 and ready=0 after 8 pushes, tx_o stays 1. Release cts_n: all 8 bytes are sent in order.
- Deassert cts_n mid-frame, or pulse flush_tx mid-frame with 3 bytes queued: the current frame completes, then the line idles; after flush tx_empty_o=1.
- Assert rst during the data bit of 0xFF: tx_o=1 immediately and outputs hold their reset values. After release, a push of 0x5A produces a correct frame.
